// File: rtl/instr_fetch_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_responder_pkg
// Purpose  : Shared types and constants for the instruction fetch responder.
//            This file holds the FSM state encoding, the NOP word returned
//            for misaligned fetches, and the byte-to-word index shift.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package instr_fetch_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fetch_state_t;

  // Returned in place of the stored word when the fetch address is misaligned.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // A byte address becomes a word index after this right shift.
  localparam int WORD_SHIFT = 2;

endpackage : instr_fetch_responder_pkg
`default_nettype wire

// File: rtl/instr_fetch_responder_store.sv
`default_nettype none
// ============================================================================
// Module   : instr_store_ram
// Purpose  : Instruction store of 2^DEPTH_LOG2 x DATA_W words. It has one
//            synchronous write port and one synchronous read port. When a
//            read and a write hit the same word on the same edge, the read
//            returns the old data. The array itself has no reset.
// Ports    : clk_i    - clock, rising edge
//            wr_en    - write strobe
//            wr_addr  - write word index
//            wr_data  - write data
//            rd_en    - read strobe; rd_data updates only when it is high
//            rd_addr  - read word index
//            rd_data  - registered read data
// Revision : 1.0 - initial release
// ============================================================================
module instr_store_ram #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk_i,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Both ports use non-blocking updates in one block. A read on the same
  // edge as a write to the same word therefore returns the old data.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule : instr_store_ram
`default_nettype wire

// File: rtl/instr_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_responder
// Purpose  : Instruction-side responder for the PC stage. It accepts a fetch
//            address, holds stall_o while the access is outstanding, and
//            returns the stored word LATENCY+1 cycles after acceptance.
//            A preload port fills the store.
// Ports    : clk_i        - clock, rising edge
//            rst_i        - asynchronous active-low reset
//            start_i      - enables acceptance of new requests
//            req_i        - fetch request valid
//            addr_i       - byte address of the fetch
//            flush_i      - abandons the outstanding fetch
//            load_we_i    - preload write strobe
//            load_addr_i  - preload word index
//            load_data_i  - preload data
//            instr_o      - returned instruction, held between responses
//            valid_o      - one-cycle response pulse
//            stall_o      - high while a fetch is outstanding
//            misaligned_o - pulses with valid_o for addr[1:0] != 0
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_responder
  import instr_fetch_responder_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  req_i,
  input  logic [31:0]           addr_i,
  input  logic                  flush_i,
  input  logic                  load_we_i,
  input  logic [DEPTH_LOG2-1:0] load_addr_i,
  input  logic [DATA_W-1:0]     load_data_i,
  output logic [DATA_W-1:0]     instr_o,
  output logic                  valid_o,
  output logic                  stall_o,
  output logic                  misaligned_o
);

  fetch_state_t          state;
  logic [3:0]            wait_cnt;
  logic [DEPTH_LOG2-1:0] pend_idx;
  logic                  pend_mis;

  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  accept;
  logic                  rd_en;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DATA_W-1:0]     rd_data;

  // The store uses only the word-index bits. Higher address bits alias.
  assign req_idx = addr_i[DEPTH_LOG2+WORD_SHIFT-1:WORD_SHIFT];

  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:DEPTH_LOG2+WORD_SHIFT];

  // A request is taken from IDLE, or back-to-back from RESP. Flush wins.
  assign accept = req_i & start_i & ~flush_i &
                  ((state == ST_IDLE) || (state == ST_RESP));

  // The store is read on the edge that enters RESP. For a zero-latency
  // fetch this is the acceptance edge, so the incoming address is used.
  // Otherwise the latched address is read at the end of WAIT.
  always_comb begin
    rd_en  = 1'b0;
    rd_idx = pend_idx;
    if (accept && (LATENCY == 0)) begin
      rd_en  = 1'b1;
      rd_idx = req_idx;
    end else if ((state == ST_WAIT) && !flush_i && (wait_cnt == 4'd0)) begin
      rd_en = 1'b1;
    end
  end

  instr_store_ram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_store (
    .clk_i   (clk_i),
    .wr_en   (load_we_i),
    .wr_addr (load_addr_i),
    .wr_data (load_data_i),
    .rd_en   (rd_en),
    .rd_addr (rd_idx),
    .rd_data (rd_data)
  );

  // Outputs are registered one edge after the state is decided. The read
  // data settles on the edge that enters RESP. valid_o and instr_o are then
  // presented on the edge that leaves RESP.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= ST_IDLE;
      wait_cnt     <= 4'd0;
      pend_idx     <= '0;
      pend_mis     <= 1'b0;
      instr_o      <= '0;
      valid_o      <= 1'b0;
      stall_o      <= 1'b0;
      misaligned_o <= 1'b0;
    end else begin
      valid_o      <= 1'b0;
      stall_o      <= 1'b0;
      misaligned_o <= 1'b0;

      case (state)
        ST_IDLE: begin
          state <= ST_IDLE;
        end
        ST_WAIT: begin
          if (flush_i) begin
            state <= ST_IDLE;
          end else if (wait_cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
            stall_o  <= 1'b1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          if (!flush_i) begin
            valid_o      <= 1'b1;
            misaligned_o <= pend_mis;
            instr_o      <= pend_mis ? DATA_W'(NOP_INSTR) : rd_data;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // An accepted request overrides the next state chosen above.
      if (accept) begin
        pend_idx <= req_idx;
        pend_mis <= |addr_i[1:0];
        if (LATENCY == 0) begin
          state <= ST_RESP;
        end else begin
          state    <= ST_WAIT;
          wait_cnt <= 4'(LATENCY - 1);
          stall_o  <= 1'b1;
        end
      end
    end
  end

endmodule : instr_fetch_responder
`default_nettype wire

// File: tb/tb_instr_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_responder
// Purpose  : Directed self-checking bench for instr_fetch_responder with
//            LATENCY=2. Inputs change on the falling edge. Outputs are
//            sampled on the falling edge, after the rising edge before it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        req_i;
  logic [31:0] addr_i;
  logic        flush_i;
  logic        load_we_i;
  logic [7:0]  load_addr_i;
  logic [31:0] load_data_i;
  logic [31:0] instr_o;
  logic        valid_o;
  logic        stall_o;
  logic        misaligned_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  instr_fetch_responder #(
    .DATA_W     (32),
    .DEPTH_LOG2 (8),
    .LATENCY    (2)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .req_i        (req_i),
    .addr_i       (addr_i),
    .flush_i      (flush_i),
    .load_we_i    (load_we_i),
    .load_addr_i  (load_addr_i),
    .load_data_i  (load_data_i),
    .instr_o      (instr_o),
    .valid_o      (valid_o),
    .stall_o      (stall_o),
    .misaligned_o (misaligned_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and stop at the following falling edge.
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic issue(input logic [31:0] a);
    req_i  = 1'b1;
    addr_i = a;
    step();
    req_i  = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; req_i = 1'b0; addr_i = 32'h0;
    flush_i = 1'b0; load_we_i = 1'b0; load_addr_i = 8'h0; load_data_i = 32'h0;
    step();
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_valid", {31'b0, valid_o}, 32'h0);
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    chk("rst_mis",   {31'b0, misaligned_o}, 32'h0);
    rst_i = 1'b1;

    // Preload words 4 and 5.
    load_we_i = 1'b1; load_addr_i = 8'd4; load_data_i = 32'h2002_0005; step();
    load_addr_i = 8'd5; load_data_i = 32'h0043_1020; step();
    load_we_i = 1'b0;
    start_i = 1'b1;

    // 1: basic fetch. Stall after edges 0 and 1, response after edge 3.
    issue(32'h10);
    chk("t1_stall_e0", {31'b0, stall_o}, 32'h1);
    step();
    chk("t1_stall_e1", {31'b0, stall_o}, 32'h1);
    step();
    chk("t1_stall_e2", {31'b0, stall_o}, 32'h0);
    chk("t1_valid_e2", {31'b0, valid_o}, 32'h0);
    step();
    chk("t1_valid", {31'b0, valid_o}, 32'h1);
    chk("t1_instr", instr_o, 32'h2002_0005);
    chk("t1_mis",   {31'b0, misaligned_o}, 32'h0);
    step();
    chk("t1_valid_off", {31'b0, valid_o}, 32'h0);
    chk("t1_instr_hold", instr_o, 32'h2002_0005);

    // 2: back-to-back. The second request is presented in the RESP state.
    issue(32'h10);
    step(); step();
    req_i = 1'b1; addr_i = 32'h14;
    step();
    req_i = 1'b0;
    chk("t2_valid1", {31'b0, valid_o}, 32'h1);
    chk("t2_instr1", instr_o, 32'h2002_0005);
    chk("t2_stall1", {31'b0, stall_o}, 32'h1);
    step();
    chk("t2_gap_e4", {31'b0, valid_o}, 32'h0);
    step();
    chk("t2_gap_e5", {31'b0, valid_o}, 32'h0);
    step();
    chk("t2_valid2", {31'b0, valid_o}, 32'h1);
    chk("t2_instr2", instr_o, 32'h0043_1020);
    step();

    // 3: flush after one WAIT cycle. The fetch that follows is normal.
    issue(32'h10);
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("t3_stall", {31'b0, stall_o}, 32'h0);
    chk("t3_valid", {31'b0, valid_o}, 32'h0);
    chk("t3_hold",  instr_o, 32'h0043_1020);
    step();
    chk("t3_no_late_valid_a", {31'b0, valid_o}, 32'h0);
    step();
    chk("t3_no_late_valid_b", {31'b0, valid_o}, 32'h0);
    issue(32'h10);
    step(); step(); step();
    chk("t3_refetch_valid", {31'b0, valid_o}, 32'h1);
    chk("t3_refetch_instr", instr_o, 32'h2002_0005);
    step();

    // 4: misaligned fetch returns a NOP with the flag set.
    issue(32'h12);
    step(); step(); step();
    chk("t4_valid", {31'b0, valid_o}, 32'h1);
    chk("t4_mis",   {31'b0, misaligned_o}, 32'h1);
    chk("t4_instr", instr_o, 32'h0);
    step();
    chk("t4_mis_off", {31'b0, misaligned_o}, 32'h0);

    // 5: aliasing, then a write during WAIT, then a write on the read edge.
    issue(32'h410);
    step(); step(); step();
    chk("t5_alias", instr_o, 32'h2002_0005);
    step();
    issue(32'h10);
    load_we_i = 1'b1; load_addr_i = 8'd4; load_data_i = 32'hDEAD_BEEF;
    step();
    load_we_i = 1'b0;
    step(); step();
    chk("t5_wait_write", instr_o, 32'hDEAD_BEEF);
    step();
    issue(32'h14);
    step();
    load_we_i = 1'b1; load_addr_i = 8'd5; load_data_i = 32'hCAFE_F00D;
    step();
    load_we_i = 1'b0;
    step();
    chk("t5_same_edge_old", instr_o, 32'h0043_1020);
    step();

    // 6: reset during WAIT clears the outputs without waiting for a clock edge.
    issue(32'h10);
    chk("t6_pre_stall", {31'b0, stall_o}, 32'h1);
    #2 rst_i = 1'b0;
    #1;
    chk("t6_rst_stall", {31'b0, stall_o}, 32'h0);
    chk("t6_rst_instr", instr_o, 32'h0);
    chk("t6_rst_valid", {31'b0, valid_o}, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    step(); step(); step();
    chk("t6_dropped", {31'b0, valid_o}, 32'h0);

    // Clearing start_i after acceptance still lets the fetch complete.
    // That fetch also reads back the earlier same-edge write.
    req_i = 1'b1; addr_i = 32'h14;
    step();
    start_i = 1'b0;
    step(); step(); step();
    chk("t6_complete_valid", {31'b0, valid_o}, 32'h1);
    chk("t6_complete_instr", instr_o, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_blocked_stall", {31'b0, stall_o}, 32'h0);
      chk("t6_blocked_valid", {31'b0, valid_o}, 32'h0);
    end
    req_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_instr_fetch_responder
`default_nettype wire
